// File: rtl/rw_serial_frame_rx.sv
// rw_serial_frame_rx: bit-serial frame receiver, one line bit per clock, W data bits LSB first.
// Ports: clk    - clock, rising edge
//        rst    - asynchronous active-low reset
//        __in0  - serial line, idles high
//        __out0 - registered {valid, err, data[W-1:0]}; valid/err are one-cycle pulses
// Frame: start(0), W data bits, [even parity bit], stop(1).
// Define RW_SERIAL_RX_PARITY_EN to insert and check the even parity bit.
module rw_serial_frame_rx #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         __in0,
   output logic [W+1:0] __out0
);
   localparam int CW = (W > 1) ? $clog2(W) : 1;
`ifdef RW_SERIAL_RX_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [W+1:0]  out_q, out_d;
   logic          bad;
`ifdef RW_SERIAL_RX_PARITY_EN
   logic          perr_q, perr_d;
   assign bad = ~__in0 | perr_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) perr_q <= 1'b0;
      else      perr_q <= perr_d;
   // Flag is cleared on every start bit so a stale mismatch never leaks into the next frame.
   always_comb begin
      perr_d = perr_q;
      if (state_q == IDLE) perr_d = 1'b0;
      if (state_q == PARITY) perr_d = ^sr_q ^ __in0;
   end
`else
   assign bad = ~__in0;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         out_q   <= out_d;
      end
   // Pulses drop back to 0 every cycle; data field holds until the next frame ends.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      out_d   = {2'b00, out_q[W-1:0]};
      case (state_q)
         IDLE: if (!__in0) begin
            state_d = DATA;
            cnt_d   = '0;
         end
         DATA: begin
            sr_d[cnt_q] = __in0;
`ifdef RW_SERIAL_RX_PARITY_EN
            if (cnt_q == CW'(W-1)) state_d = PARITY;
`else
            if (cnt_q == CW'(W-1)) state_d = STOP;
`endif
            else cnt_d = cnt_q + CW'(1);
         end
`ifdef RW_SERIAL_RX_PARITY_EN
         PARITY: state_d = STOP;
`endif
         STOP: begin
            out_d   = {~bad, bad, sr_q};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign __out0 = out_q;
endmodule

// File: tb/tb_rw_serial_frame_rx.sv
// tb_rw_serial_frame_rx: randomized and directed frames checked cycle by cycle against a frame-level model.
module tb_rw_serial_frame_rx;
   localparam int W = 8;
`ifdef RW_SERIAL_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         line = 1'b1;
   logic [W+1:0] out;
   int           n_cmp = 0;
   int           n_err = 0;
   bit           bq[$];
   logic [W+1:0] expq[$];
   logic [W-1:0] held = '0;

   rw_serial_frame_rx #(.W(W)) dut (.clk(clk), .rst(rst), .__in0(line), .__out0(out));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W+1:0] got, input logic [W+1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) begin
         bq.push_back(1'b1);
         expq.push_back({2'b00, held});
      end
   endtask

   // Appends one frame; the result pulse is expected right after the edge that samples the stop bit.
   task automatic add_frame(input logic [W-1:0] d, input bit good_stop, input bit good_par, input int gap);
      bit ok;
      bit gp;
      gp = PAR ? good_par : 1'b1;
      ok = good_stop && gp;
      bq.push_back(1'b0);
      expq.push_back({2'b00, held});
      for (int i = 0; i < W; i++) begin
         bq.push_back(d[i]);
         expq.push_back({2'b00, held});
      end
      if (PAR) begin
         bq.push_back(gp ? ^d : ~^d);
         expq.push_back({2'b00, held});
      end
      bq.push_back(good_stop);
      expq.push_back({ok, ~ok, d});
      held = d;
      add_idle(gap);
   endtask

   task automatic run(input string tag);
      for (int k = 0; k < bq.size(); k++) begin
         line = bq[k];
         @(posedge clk);
         #1 chk(tag, out, expq[k]);
      end
      bq.delete();
      expq.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk("reset", out, '0);
      @(negedge clk) rst = 1'b1;
      add_idle(20);
      run("idle");
      add_frame(8'hA5, 1, 1, 2);
      run("a5");
      add_frame(8'h3C, 1, 1, 0);
      add_frame(8'hFF, 1, 1, 2);
      run("b2b");
      add_frame(8'h81, 0, 1, 1);
      add_frame(8'h42, 1, 1, 1);
      run("badstop");
      add_frame(8'h07, 1, 1, 1);
      add_frame(8'h07, 1, 0, 1);
      add_frame(8'h07, 1, 1, 0);
      run("parity");
      bq.push_back(1'b0);
      expq.push_back({2'b00, held});
      for (int i = 0; i < 4; i++) begin
         bq.push_back(((W'(8'h5A)) >> i) & 1);
         expq.push_back({2'b00, held});
      end
      run("partial");
      #2 rst = 1'b0;
      #1 chk("rst_async", out, '0);
      held = '0;
      @(posedge clk);
      #1 chk("rst_hold", out, '0);
      @(negedge clk) begin rst = 1'b1; line = 1'b1; end
      add_idle(1);
      add_frame(8'h12, 1, 1, 2);
      run("after_rst");
      for (int f = 0; f < 60; f++) begin
         bit bs;
         bit bp;
         bs = ($urandom_range(0, 5) != 0);
         bp = ($urandom_range(0, 5) != 0);
         add_frame(W'($urandom), bs, bp, $urandom_range(0, 2));
      end
      add_idle(3);
      run("random");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rw_serial_frame_rx.md
Name: rw_serial_frame_rx

Overview:
- Bit-serial frame receiver: deserializes one line bit per clock into W-bit words with framing check.
- Receive end of the team's 1-bit-per-cycle serial link; the paired serializer drives the line.
- Produces a registered output vector per frame, in the packed single-vector output style of the team's generated top levels.

Parameters:
W, 8, data bits per frame (1..32), sent LSB first.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset; rst == 0 forces reset state immediately.
__in0  input  1  serial line; idles high (1).
__out0  output  W+2  {valid, err, data[W-1:0]}; registered.

Behaviour:
- Frame on line: start bit (0), W data bits LSB first, [parity bit if enabled], stop bit (1). One bit per clock, no oversampling.
- Reset (rst low, asynchronous): state=IDLE, bit counter=0, shift reg=0, __out0=0 (valid=0, err=0, data=0). Release is synchronous to the next clk edge.
- State IDLE:
  - __in0==1: stay.
  - __in0==0: start bit taken; go to DATA, counter=0.
- State DATA:
  - Each cycle, shift __in0 into bit [counter] of the shift reg; counter+1.
  - After bit W-1 is sampled: go to PARITY if enabled, else STOP.
  - Counter width = clog2(W) bits, minimum 1; never wraps within a frame.
- State PARITY (compiled in only): sample the parity bit, compare with the computed value, latch a mismatch flag; go to STOP.
- State STOP: sample the stop bit.
  - Stop == 1 and no parity mismatch: next cycle valid=1, err=0, data=shift reg.
  - Stop == 0 or parity mismatch: next cycle valid=0, err=1, data=shift reg (diagnostic).
  - Always return to IDLE.
- Latency: result appears on __out0 in the cycle immediately after the stop-bit edge. Frame = W+2 cycles (W+3 with parity).
- valid and err are single-cycle pulses and mutually exclusive.
- data holds its last value until the next frame completes or a reset occurs.
- Back-to-back frames: a start bit in the cycle directly after the stop bit is accepted, because IDLE is entered on the stop edge.
  - Consecutive valid pulses are exactly W+2 cycles apart.
- Broken stop bit (0): reported as err, then IDLE. If the line is still 0 in the next cycle, that cycle is taken as a new start bit; no break detection.
- Reset mid-frame: partial frame discarded; no valid/err pulse is generated for it.
- No backpressure: the consumer must take __out0 in the valid cycle.

Optional Feature:
- Macro: RW_SERIAL_RX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Even parity: the XOR of the W data bits and the parity bit must be 0, otherwise err.
  - Frame = W+3 cycles.
- Undefined:
  - No PARITY state and no parity logic.
  - Frame = W+2 cycles; err is raised only by a bad stop bit.

Test Plan:
- Reset then line held 1 for 20 cycles -> __out0 stays 0 throughout; no pulses.
- W=8, line 0,1,0,1,0,0,1,0,1,1 (0xA5, good stop) -> in the cycle after the stop bit: valid=1, err=0, data=0xA5; next cycle: valid=0, data still 0xA5.
- Two frames 0x3C then 0xFF back-to-back, no idle gap -> two valid pulses 10 cycles apart with data 0x3C, then 0xFF.
- Frame 0x81 with stop bit 0, then line 1 -> err=1, valid=0, data=0x81 for one cycle; the next 0 on the line starts a new frame correctly.
- rst pulsed low for 1 cycle after 4 data bits of 0x5A, then a full 0x12 frame -> __out0 goes to 0 immediately on rst low; no pulse for the aborted frame; valid pulse with data=0x12 afterwards.
- With RW_SERIAL_RX_PARITY_EN: frame 0x07 with parity 1 -> valid, data=0x07; same frame with parity 0 -> err=1, valid=0; frame length 11 cycles.
